// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: control-word bit positions, bubble constant,
// EX-slot action encoding and the saturating counter helper.
package pipeline_pkg;

    localparam int unsigned NB_CTRL_DEF = 16;
    localparam int unsigned NB_COUNT    = 16;

    localparam int unsigned CTRL_REG_WRITE  = 0;
    localparam int unsigned CTRL_MEM_READ   = 1;
    localparam int unsigned CTRL_MEM_WRITE  = 2;
    localparam int unsigned CTRL_MEM_TO_REG = 3;
    localparam int unsigned CTRL_ALU_SRC    = 4;
    localparam int unsigned CTRL_BRANCH     = 5;

    localparam logic [NB_CTRL_DEF-1:0] CTRL_BUBBLE = '0;

    typedef enum logic [1:0] {
        ACT_HOLD   = 2'd0,
        ACT_LOAD   = 2'd1,
        ACT_BUBBLE = 2'd2
    } ex_action_e;

    function automatic logic [NB_COUNT-1:0] sat_inc(input logic [NB_COUNT-1:0] v);
        return (v == {NB_COUNT{1'b1}}) ? v : v + NB_COUNT'(1);
    endfunction

endpackage

// File: rtl/load_use_detector.sv
// Flags a load in EX whose destination is read by the instruction in decode.
module load_use_detector #(
    parameter int unsigned NB_REG = 5
) (
    input  logic              i_ex_valid,
    input  logic              i_ex_mem_read,
    input  logic [NB_REG-1:0] i_ex_rt,
    input  logic              i_id_valid,
    input  logic [NB_REG-1:0] i_id_rs,
    input  logic [NB_REG-1:0] i_id_rt,
    input  logic              i_id_uses_rt,
    output logic              o_stall
);

    logic rs_match;
    logic rt_match;

    // Register 0 is never a real destination, so it can never create a hazard.
    always_comb begin
        rs_match = (i_ex_rt == i_id_rs);
        rt_match = i_id_uses_rt && (i_ex_rt == i_id_rt);
        o_stall  = i_ex_valid && i_ex_mem_read && i_id_valid
                   && (i_ex_rt != '0) && (rs_match || rt_match);
    end

endmodule

// File: rtl/id_ex_latch.sv
// ID/EX pipeline register with load-use bubble insertion, flush handling and
// a saturating count of discarded decode instructions.
module id_ex_latch
    import pipeline_pkg::*;
#(
    parameter int unsigned NB_DATA = 32,
    parameter int unsigned NB_REG  = 5,
    parameter int unsigned NB_CTRL = NB_CTRL_DEF
) (
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic                i_step,
    input  logic                i_flush,
    input  logic                i_id_valid,
    input  logic [NB_DATA-1:0]  i_id_pc4,
    input  logic [NB_DATA-1:0]  i_id_rs_data,
    input  logic [NB_DATA-1:0]  i_id_rt_data,
    input  logic [NB_DATA-1:0]  i_id_ext_imm,
    input  logic [NB_REG-1:0]   i_id_rs,
    input  logic [NB_REG-1:0]   i_id_rt,
    input  logic [NB_REG-1:0]   i_id_rd,
    input  logic                i_id_uses_rt,
    input  logic [NB_CTRL-1:0]  i_id_ctrl,
    output logic                o_ex_valid,
    output logic [NB_DATA-1:0]  o_ex_pc4,
    output logic [NB_DATA-1:0]  o_ex_rs_data,
    output logic [NB_DATA-1:0]  o_ex_rt_data,
    output logic [NB_DATA-1:0]  o_ex_ext_imm,
    output logic [NB_REG-1:0]   o_ex_rs,
    output logic [NB_REG-1:0]   o_ex_rt,
    output logic [NB_REG-1:0]   o_ex_rd,
    output logic [NB_CTRL-1:0]  o_ex_ctrl,
    output logic                o_load_use_stall,
    output logic [NB_COUNT-1:0] o_bubble_count
);

    logic                valid_q,   valid_d;
    logic [NB_DATA-1:0]  pc4_q,     pc4_d;
    logic [NB_DATA-1:0]  rs_data_q, rs_data_d;
    logic [NB_DATA-1:0]  rt_data_q, rt_data_d;
    logic [NB_DATA-1:0]  ext_imm_q, ext_imm_d;
    logic [NB_REG-1:0]   rs_q,      rs_d;
    logic [NB_REG-1:0]   rt_q,      rt_d;
    logic [NB_REG-1:0]   rd_q,      rd_d;
    logic [NB_CTRL-1:0]  ctrl_q,    ctrl_d;
    logic [NB_COUNT-1:0] count_q,   count_d;

    ex_action_e action;
    logic       stall;

    load_use_detector #(
        .NB_REG (NB_REG)
    ) u_load_use_detector (
        .i_ex_valid    (valid_q),
        .i_ex_mem_read (ctrl_q[CTRL_MEM_READ]),
        .i_ex_rt       (rt_q),
        .i_id_valid    (i_id_valid),
        .i_id_rs       (i_id_rs),
        .i_id_rt       (i_id_rt),
        .i_id_uses_rt  (i_id_uses_rt),
        .o_stall       (stall)
    );

    // Flush outranks the hazard; either one yields a single bubble.
    always_comb begin
        action = ACT_HOLD;
        if (i_step) begin
            if (i_flush || stall) begin
                action = ACT_BUBBLE;
            end else begin
                action = ACT_LOAD;
            end
        end
    end

    always_comb begin
        valid_d   = valid_q;
        pc4_d     = pc4_q;
        rs_data_d = rs_data_q;
        rt_data_d = rt_data_q;
        ext_imm_d = ext_imm_q;
        rs_d      = rs_q;
        rt_d      = rt_q;
        rd_d      = rd_q;
        ctrl_d    = ctrl_q;
        count_d   = count_q;
        unique case (action)
            ACT_LOAD: begin
                valid_d   = i_id_valid;
                pc4_d     = i_id_pc4;
                rs_data_d = i_id_rs_data;
                rt_data_d = i_id_rt_data;
                ext_imm_d = i_id_ext_imm;
                rs_d      = i_id_rs;
                rt_d      = i_id_rt;
                rd_d      = i_id_rd;
                ctrl_d    = i_id_ctrl;
            end
            ACT_BUBBLE: begin
                // Zero every field so a bubble never leaks stale operands.
                valid_d   = 1'b0;
                pc4_d     = '0;
                rs_data_d = '0;
                rt_data_d = '0;
                ext_imm_d = '0;
                rs_d      = '0;
                rt_d      = '0;
                rd_d      = '0;
                ctrl_d    = NB_CTRL'(CTRL_BUBBLE);
                if (i_id_valid) begin
                    count_d = sat_inc(count_q);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            valid_q   <= 1'b0;
            pc4_q     <= '0;
            rs_data_q <= '0;
            rt_data_q <= '0;
            ext_imm_q <= '0;
            rs_q      <= '0;
            rt_q      <= '0;
            rd_q      <= '0;
            ctrl_q    <= '0;
            count_q   <= '0;
        end else begin
            valid_q   <= valid_d;
            pc4_q     <= pc4_d;
            rs_data_q <= rs_data_d;
            rt_data_q <= rt_data_d;
            ext_imm_q <= ext_imm_d;
            rs_q      <= rs_d;
            rt_q      <= rt_d;
            rd_q      <= rd_d;
            ctrl_q    <= ctrl_d;
            count_q   <= count_d;
        end
    end

    assign o_ex_valid       = valid_q;
    assign o_ex_pc4         = pc4_q;
    assign o_ex_rs_data     = rs_data_q;
    assign o_ex_rt_data     = rt_data_q;
    assign o_ex_ext_imm     = ext_imm_q;
    assign o_ex_rs          = rs_q;
    assign o_ex_rt          = rt_q;
    assign o_ex_rd          = rd_q;
    assign o_ex_ctrl        = ctrl_q;
    assign o_load_use_stall = stall;
    assign o_bubble_count   = count_q;

endmodule

// File: tb/tb_id_ex_latch.sv
// Directed bench for id_ex_latch: a behavioural model pushes the expected EX
// state to a scoreboard queue each edge, popped and compared after the edge.
module tb_id_ex_latch;
    import pipeline_pkg::*;

    logic        i_clk = 1'b0;
    logic        i_reset;
    logic        i_step;
    logic        i_flush;
    logic        i_id_valid;
    logic [31:0] i_id_pc4, i_id_rs_data, i_id_rt_data, i_id_ext_imm;
    logic [4:0]  i_id_rs, i_id_rt, i_id_rd;
    logic        i_id_uses_rt;
    logic [15:0] i_id_ctrl;
    logic        o_ex_valid;
    logic [31:0] o_ex_pc4, o_ex_rs_data, o_ex_rt_data, o_ex_ext_imm;
    logic [4:0]  o_ex_rs, o_ex_rt, o_ex_rd;
    logic [15:0] o_ex_ctrl;
    logic        o_load_use_stall;
    logic [15:0] o_bubble_count;

    always #5 i_clk = ~i_clk;

    id_ex_latch #(.NB_DATA(32), .NB_REG(5), .NB_CTRL(16)) dut (
        .i_clk(i_clk), .i_reset(i_reset), .i_step(i_step), .i_flush(i_flush),
        .i_id_valid(i_id_valid), .i_id_pc4(i_id_pc4), .i_id_rs_data(i_id_rs_data),
        .i_id_rt_data(i_id_rt_data), .i_id_ext_imm(i_id_ext_imm), .i_id_rs(i_id_rs),
        .i_id_rt(i_id_rt), .i_id_rd(i_id_rd), .i_id_uses_rt(i_id_uses_rt),
        .i_id_ctrl(i_id_ctrl), .o_ex_valid(o_ex_valid), .o_ex_pc4(o_ex_pc4),
        .o_ex_rs_data(o_ex_rs_data), .o_ex_rt_data(o_ex_rt_data),
        .o_ex_ext_imm(o_ex_ext_imm), .o_ex_rs(o_ex_rs), .o_ex_rt(o_ex_rt),
        .o_ex_rd(o_ex_rd), .o_ex_ctrl(o_ex_ctrl), .o_load_use_stall(o_load_use_stall),
        .o_bubble_count(o_bubble_count)
    );

    typedef struct {
        logic        valid;
        logic [31:0] pc4, rs_data, rt_data, ext_imm;
        logic [4:0]  rs, rt, rd;
        logic [15:0] ctrl, count;
    } exp_t;

    localparam logic [15:0] LW_CTRL = 16'h000B;

    exp_t m;
    exp_t zero_st;
    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    task automatic cmp_state(input string tag, input exp_t e);
        chk({tag, "_valid"},   32'(o_ex_valid),     32'(e.valid));
        chk({tag, "_pc4"},     o_ex_pc4,            e.pc4);
        chk({tag, "_rs_data"}, o_ex_rs_data,        e.rs_data);
        chk({tag, "_rt_data"}, o_ex_rt_data,        e.rt_data);
        chk({tag, "_ext_imm"}, o_ex_ext_imm,        e.ext_imm);
        chk({tag, "_rs"},      32'(o_ex_rs),        32'(e.rs));
        chk({tag, "_rt"},      32'(o_ex_rt),        32'(e.rt));
        chk({tag, "_rd"},      32'(o_ex_rd),        32'(e.rd));
        chk({tag, "_ctrl"},    32'(o_ex_ctrl),      32'(e.ctrl));
        chk({tag, "_count"},   32'(o_bubble_count), 32'(e.count));
    endtask

    function automatic logic model_stall();
        logic hit;
        hit = (m.rt == i_id_rs) || (i_id_uses_rt && (m.rt == i_id_rt));
        return m.valid && m.ctrl[1] && i_id_valid && (m.rt != 5'd0) && hit;
    endfunction

    task automatic model_edge();
        logic [15:0] cnt;
        if (!i_step) return;
        if (i_flush || model_stall()) begin
            cnt = m.count;
            if (i_id_valid && cnt != 16'hFFFF) cnt = cnt + 16'd1;
            m = zero_st;
            m.count = cnt;
        end else begin
            m.valid = i_id_valid;   m.pc4 = i_id_pc4;
            m.rs_data = i_id_rs_data; m.rt_data = i_id_rt_data;
            m.ext_imm = i_id_ext_imm;
            m.rs = i_id_rs; m.rt = i_id_rt; m.rd = i_id_rd; m.ctrl = i_id_ctrl;
        end
    endtask

    task automatic set_id(input logic v, input logic [31:0] pc4, input logic [31:0] rsd,
                          input logic [31:0] rtd, input logic [31:0] imm, input logic [4:0] rs,
                          input logic [4:0] rt, input logic [4:0] rd, input logic uses_rt,
                          input logic [15:0] ctrl);
        i_id_valid = v; i_id_pc4 = pc4; i_id_rs_data = rsd; i_id_rt_data = rtd;
        i_id_ext_imm = imm; i_id_rs = rs; i_id_rt = rt; i_id_rd = rd;
        i_id_uses_rt = uses_rt; i_id_ctrl = ctrl;
    endtask

    task automatic step(input string tag);
        exp_t e;
        #1;
        chk({tag, "_stall"}, 32'(o_load_use_stall), 32'(model_stall()));
        model_edge();
        sb.push_back(m);
        @(posedge i_clk); #1;
        e = sb.pop_front();
        cmp_state(tag, e);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        zero_st = '{valid: 1'b0, pc4: '0, rs_data: '0, rt_data: '0, ext_imm: '0,
                    rs: '0, rt: '0, rd: '0, ctrl: '0, count: '0};
        m = zero_st;
        i_step = 1'b0; i_flush = 1'b0;
        set_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0);
        i_reset = 1'b1;
        repeat (2) @(posedge i_clk);
        #2 i_reset = 1'b0;
        cmp_state("reset", zero_st);
        chk("reset_stall", 32'(o_load_use_stall), 32'd0);

        // Asynchronous reset between edges clears a loaded slot immediately.
        i_step = 1'b1;
        set_id(1, 32'h0000_0404, 32'h1111_1111, 32'h2222_2222, 32'h0000_0010, 5'd9, 5'd10, 5'd11, 1, 16'h0021);
        step("pre_reset_load");
        #2 i_reset = 1'b1;
        #1;
        cmp_state("reset_mid", zero_st);
        chk("reset_mid_stall", 32'(o_load_use_stall), 32'd0);
        m = zero_st;
        #1 i_reset = 1'b0;

        set_id(1, 32'h0000_1004, 32'hAAAA_0001, 32'hBBBB_0002, 32'hFFFF_8000, 5'd3, 5'd4, 5'd2, 1, 16'h0011);
        step("plain");
        chk("plain_ext_imm_const", o_ex_ext_imm, 32'hFFFF_8000);
        chk("plain_rs_const", 32'(o_ex_rs), 32'd3);
        chk("plain_ctrl_const", 32'(o_ex_ctrl), 32'h0011);
        chk("plain_valid_const", 32'(o_ex_valid), 32'd1);

        // Load-use: LW rt=5 in EX, consumer reads rs=5.
        set_id(1, 32'h0000_2004, 32'h0, 32'h0, 32'h4, 5'd1, 5'd5, 5'd0, 0, LW_CTRL);
        step("lw5");
        set_id(1, 32'h0000_2008, 32'h1234_5678, 32'h9ABC_DEF0, 32'h8, 5'd5, 5'd6, 5'd7, 1, 16'h0001);
        #1 chk("lu_stall_const", 32'(o_load_use_stall), 32'd1);
        step("lu_bubble");
        chk("lu_count_const", 32'(o_bubble_count), 32'd1);
        chk("lu_bubble_valid_const", 32'(o_ex_valid), 32'd0);
        step("lu_reload");
        chk("lu_reload_rs_const", 32'(o_ex_rs), 32'd5);
        chk("lu_reload_valid_const", 32'(o_ex_valid), 32'd1);

        // Register 0 and rt-use gating.
        set_id(1, 32'h0000_3004, 0, 0, 0, 5'd2, 5'd0, 5'd0, 0, LW_CTRL);
        step("lw0");
        set_id(1, 32'h0000_3008, 0, 0, 0, 5'd0, 5'd0, 5'd3, 1, 16'h0001);
        #1 chk("r0_nostall_const", 32'(o_load_use_stall), 32'd0);
        set_id(1, 32'h0000_300C, 0, 0, 0, 5'd2, 5'd7, 5'd0, 0, LW_CTRL);
        step("lw7");
        set_id(1, 32'h0000_3010, 0, 0, 0, 5'd1, 5'd7, 5'd8, 0, 16'h0001);
        #1 chk("rt_unused_nostall_const", 32'(o_load_use_stall), 32'd0);
        i_id_uses_rt = 1'b1;
        #1 chk("rt_used_stall_const", 32'(o_load_use_stall), 32'd1);
        i_id_uses_rt = 1'b0;
        step("rt_gate_load");

        // Flush alone, flush with hazard, flush with invalid decode slot.
        set_id(1, 32'h0000_4004, 0, 0, 0, 5'd1, 5'd9, 5'd0, 0, LW_CTRL);
        i_flush = 1'b1;
        step("flush_alone");
        chk("flush_alone_count_const", 32'(o_bubble_count), 32'd2);
        i_flush = 1'b0;
        step("lw9");
        set_id(1, 32'h0000_4008, 0, 0, 0, 5'd9, 5'd1, 5'd2, 0, 16'h0001);
        i_flush = 1'b1;
        step("flush_hazard");
        chk("flush_hazard_count_const", 32'(o_bubble_count), 32'd3);
        i_id_valid = 1'b0;
        step("flush_invalid");
        chk("flush_invalid_count_const", 32'(o_bubble_count), 32'd3);
        i_flush = 1'b0;
        set_id(1, 32'h0000_5004, 32'h5, 32'h6, 32'h7, 5'd4, 5'd12, 5'd13, 1, LW_CTRL);
        step("pre_gate_load");

        // Stepping disabled: state holds while inputs churn.
        i_step = 1'b0;
        for (int i = 0; i < 10; i++) begin
            set_id(1'($urandom), $urandom, $urandom, $urandom, $urandom, 5'($urandom),
                   5'($urandom), 5'($urandom), 1'($urandom), 16'($urandom));
            i_flush = 1'($urandom);
            step("step_gate");
        end
        chk("step_gate_rt_const", 32'(o_ex_rt), 32'd12);
        chk("step_gate_count_const", 32'(o_bubble_count), 32'd3);

        // Saturation via repeated valid flushes.
        i_step = 1'b1; i_flush = 1'b1; i_id_valid = 1'b1;
        for (int i = 0; i < 70000 && m.count != 16'hFFFF; i++) begin
            model_edge();
            @(posedge i_clk); #1;
        end
        chk("sat_reach_const", 32'(o_bubble_count), 32'h0000_FFFF);
        step("sat_hold1");
        step("sat_hold2");
        chk("sat_stick_const", 32'(o_bubble_count), 32'h0000_FFFF);
        i_flush = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/id_ex_latch.md
# id_ex_latch

Decode-to-execute pipeline register for the MIPS pipeline. It captures the decode-stage bundle each enabled cycle: PC+4, the two register-file operands, the sign-extender's 32-bit result, the register addresses and the control word. It also detects load-use hazards and inserts bubbles for both hazards and branch flushes. It keeps a saturating bubble counter for the debug unit.

## Interface
Parameters:
- NB_DATA, 32, width of PC, operands and extended immediate
- NB_REG, 5, register address width
- NB_CTRL, 16, control word width; bit positions fixed in package

Ports:
- i_clk  in  1  clock, rising edge
- i_reset  in  1  asynchronous, active-high reset
- i_step  in  1  pipeline advance enable (debug step / run)
- i_flush  in  1  branch-resolution flush request
- i_id_valid  in  1  decode slot holds a real instruction
- i_id_pc4  in  NB_DATA  PC+4 of decode instruction
- i_id_rs_data, i_id_rt_data  in  NB_DATA  register-file read data
- i_id_ext_imm  in  NB_DATA  sign-extender output
- i_id_rs, i_id_rt, i_id_rd  in  NB_REG  register addresses
- i_id_uses_rt  in  1  instruction reads rt as a source
- i_id_ctrl  in  NB_CTRL  decoded control word
- o_ex_valid  out  1  EX slot valid
- o_ex_pc4, o_ex_rs_data, o_ex_rt_data, o_ex_ext_imm  out  NB_DATA  registered copies
- o_ex_rs, o_ex_rt, o_ex_rd  out  NB_REG  registered copies
- o_ex_ctrl  out  NB_CTRL  registered control word
- o_load_use_stall  out  1  hold PC and IF/ID this cycle
- o_bubble_count  out  16  bubbles inserted since reset, saturating

## Operation
- Hazard signal (combinational): o_load_use_stall = o_ex_valid & o_ex_ctrl[CTRL_MEM_READ] & i_id_valid & (o_ex_rt != 0) & ((o_ex_rt == i_id_rs) | (i_id_uses_rt & (o_ex_rt == i_id_rt))).
- Each rising edge with i_step=1, exactly one action is taken, in priority order:
  - **FLUSH**: i_flush=1 → bubble.
  - **HAZARD**: o_load_use_stall=1 → bubble.
  - **LOAD**: otherwise → capture every i_id_* field; o_ex_valid ← i_id_valid.
- Bubble means: o_ex_valid=0, o_ex_ctrl=0, and all data and address fields =0 (deterministic, not hold).
- Counter:
  - o_bubble_count increments by 1 on every bubble where the slot being discarded or blocked had i_id_valid=1.
  - A flush or hazard with i_id_valid=0 does not count.
  - Saturates at 16'hFFFF.
- i_step=0: all registers hold, counter holds. o_load_use_stall still evaluates combinationally, and the upstream stage must ignore it while stepping is disabled.
- A load-use stall lasts exactly one enabled cycle: after the bubble, EX is no longer a valid load.
- Writes to register 0 are not a hazard (o_ex_rt==0 excluded).

## Timing
- Reset (asynchronous, any time, including mid-stall): every output register =0, o_bubble_count=0, so o_load_use_stall=0. After reset release, the first i_step edge performs LOAD (or FLUSH if asserted).
- Latency: i_id_* to o_ex_* is one enabled edge.
- o_load_use_stall has zero latency: it is combinational from registered EX state and current ID inputs.
- Simultaneous i_flush and hazard: one bubble, counted once.
- Counter update and register update occur on the same edge.

## Structure
- Shared package (pipeline_pkg): CTRL_REG_WRITE=0, CTRL_MEM_READ=1, CTRL_MEM_WRITE=2, CTRL_MEM_TO_REG=3, CTRL_ALU_SRC=4, CTRL_BRANCH=5, NB_CTRL default, and a bubble constant (all zeros).
- One sub-module: load_use_detector, a pure combinational comparator producing o_load_use_stall. The register bank and counter stay in id_ex_latch.

## Test plan
- **Reset mid-operation**:
  - Stimulus: load a valid bundle, assert i_reset between edges.
  - Response: all outputs 0 immediately, before the next clock; count=0.
- **Plain load**:
  - Stimulus: i_step=1, i_id_ext_imm=32'hFFFF8000, i_id_rs=3, ctrl=16'h0011.
  - Response: after one edge, o_ex_ext_imm=32'hFFFF8000, o_ex_rs=3, o_ex_ctrl=16'h0011, valid=1.
- **Load-use**:
  - Stimulus: EX holds LW with rt=5; ID instruction has rs=5.
  - Response: o_load_use_stall=1; next edge gives a bubble with count=1; on the following edge the same ID bundle loads.
- **Register 0 and rt gating**:
  - Stimulus: EX LW with rt=0 and ID rs=0 → no stall. EX LW with rt=7, ID rt=7, i_id_uses_rt=0.
  - Response: no stall in either case.
- **Flush vs hazard**:
  - Stimulus: flush alone, then flush together with hazard, with i_id_valid=1.
  - Response: one bubble each time, count +1 each time. A flush with i_id_valid=0 leaves the count unchanged.
- **Step gating and saturation**:
  - Stimulus: i_step=0 for 10 cycles with changing inputs.
  - Response: outputs unchanged.
  - Stimulus: preload the count near 16'hFFFF by forcing repeated flushes.
  - Response: the count sticks at 16'hFFFF.
